// File: rtl/dsp_pkg.sv
// Shared definitions for the dsp_mac_pipe MAC slice.
// Contents: OPMODE bit positions, accumulator FSM state, saturation-limit helper.
// No ports; imported by the top.
package dsp_pkg;

  // OPMODE bit positions
  localparam int OP_PRE_EN  = 0;  // pre-adder enable (else B passes through)
  localparam int OP_PRE_SUB = 1;  // pre-adder computes D-B instead of D+B
  localparam int OP_ACC_SUB = 2;  // product is subtracted from the accumulator

  // Widest accumulator the limit helper can describe
  localparam int SAT_MAXW = 128;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  // Signed clamp value for a 'width'-bit word, sign-extended to SAT_MAXW bits:
  // neg=1 gives -2^(width-1), neg=0 gives 2^(width-1)-1. Callers size-cast it.
  function automatic logic [SAT_MAXW-1:0] sat_limit(input int unsigned width, input logic neg);
    logic [SAT_MAXW-1:0] lo;
    lo = {SAT_MAXW{1'b1}} << (width - 1);
    return neg ? lo : ~lo;
  endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Purpose: one pipeline register slice, loads i_d when i_en is high, holds otherwise.
// Latency: 1 cycle. Backpressure: i_en low freezes the contents.
// Ports: i_clk, i_rst_n (async active-low, clears to 0), i_en, i_d -> o_q.
module dsp_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Purpose: signed pre-add / multiply / framed accumulate slice with optional saturation.
// Latency: a LAST beat accepted at edge n shows P_VALID after edge n+3; 1 beat/cycle.
// Backpressure: P_VALID && !P_READY freezes every stage and drops IN_READY.
// Ports: CLK, RSTN; input beat IN_VALID/IN_READY with A,B,D,C,OPMODE,IN_FIRST,IN_LAST;
//        result P_VALID/P_READY with P,P_OVF,P_BEATS; FRAME_ERR pulse on aborted frame.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int ABD_WIDTH = 18,
  parameter int CP_WIDTH  = 48,
  parameter bit SATURATE  = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [ABD_WIDTH-1:0] A,
  input  logic [ABD_WIDTH-1:0] B,
  input  logic [ABD_WIDTH-1:0] D,
  input  logic [CP_WIDTH-1:0]  C,
  input  logic [2:0]           OPMODE,
  input  logic                 IN_FIRST,
  input  logic                 IN_LAST,
  output logic                 P_VALID,
  input  logic                 P_READY,
  output logic [CP_WIDTH-1:0]  P,
  output logic                 P_OVF,
  output logic [CNT_WIDTH-1:0] P_BEATS,
  output logic                 FRAME_ERR
);

  localparam int W   = ABD_WIDTH;
  localparam int PW  = 2*W + 1;              // product width
  localparam int XW  = CP_WIDTH + 1;         // one guard bit for overflow detection
  localparam int S1W = 3*W + CP_WIDTH + 5;   // A,B,D,C,OPMODE,FIRST,LAST
  localparam int S2W = (W+1) + W + CP_WIDTH + 3;
  localparam int S3W = PW + CP_WIDTH + 3;

  logic r_run;
  logic w_adv, w_acc_in;

  // IN_READY stays low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_run <= 1'b0;
    else       r_run <= 1'b1;
  end

  assign w_adv    = !(P_VALID && !P_READY);
  assign IN_READY = w_adv && r_run;
  assign w_acc_in = IN_VALID && IN_READY;

  // ---------------- stage 1: input register ----------------
  logic [S1W-1:0]       r_s1;
  logic                 r_s1_vld;
  logic [W-1:0]         w_s1_a, w_s1_b, w_s1_d;
  logic [CP_WIDTH-1:0]  w_s1_c;
  logic [2:0]           w_s1_op;
  logic                 w_s1_first, w_s1_last;

  dsp_pipe_reg #(.WIDTH(S1W)) u_s1_dat (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d({A, B, D, C, OPMODE, IN_FIRST, IN_LAST}), .o_q(r_s1));
  dsp_pipe_reg #(.WIDTH(1)) u_s1_vld (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d(w_acc_in), .o_q(r_s1_vld));

  assign {w_s1_a, w_s1_b, w_s1_d, w_s1_c, w_s1_op, w_s1_first, w_s1_last} = r_s1;

  // ---------------- stage 2: pre-adder, then multiplier ----------------
  // The pre-adder result gets its own register so the add and the multiply
  // never share a timing path; the product is registered behind it.
  logic [W:0] w_b_x, w_d_x, w_pre;
  assign w_b_x = {w_s1_b[W-1], w_s1_b};
  assign w_d_x = {w_s1_d[W-1], w_s1_d};
  assign w_pre = w_s1_op[OP_PRE_EN] ? (w_s1_op[OP_PRE_SUB] ? (w_d_x - w_b_x) : (w_d_x + w_b_x))
                                    : w_b_x;

  logic [S2W-1:0]      r_s2;
  logic                r_s2_vld;
  logic [W:0]          w_s2_pre;
  logic [W-1:0]        w_s2_a;
  logic [CP_WIDTH-1:0] w_s2_c;
  logic                w_s2_sub, w_s2_first, w_s2_last;

  dsp_pipe_reg #(.WIDTH(S2W)) u_s2_dat (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d({w_pre, w_s1_a, w_s1_c, w_s1_op[OP_ACC_SUB], w_s1_first, w_s1_last}), .o_q(r_s2));
  dsp_pipe_reg #(.WIDTH(1)) u_s2_vld (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d(r_s1_vld), .o_q(r_s2_vld));

  assign {w_s2_pre, w_s2_a, w_s2_c, w_s2_sub, w_s2_first, w_s2_last} = r_s2;

  // Both operands sign-extended to full product width: the low PW bits of
  // the unsigned product are then the exact signed product.
  logic [PW-1:0] w_pre_x, w_a_x, w_m;
  assign w_pre_x = {{W{w_s2_pre[W]}}, w_s2_pre};
  assign w_a_x   = {{(W+1){w_s2_a[W-1]}}, w_s2_a};
  assign w_m     = w_pre_x * w_a_x;

  logic [S3W-1:0]      r_s3;
  logic                r_s3_vld;
  logic [PW-1:0]       w_m3;
  logic [CP_WIDTH-1:0] w_c3;
  logic                w_sub3, w_first3, w_last3;

  dsp_pipe_reg #(.WIDTH(S3W)) u_s3_dat (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d({w_m, w_s2_c, w_s2_sub, w_s2_first, w_s2_last}), .o_q(r_s3));
  dsp_pipe_reg #(.WIDTH(1)) u_s3_vld (.i_clk(CLK), .i_rst_n(RSTN), .i_en(w_adv),
    .i_d(r_s2_vld), .o_q(r_s3_vld));

  assign {w_m3, w_c3, w_sub3, w_first3, w_last3} = r_s3;

  // ---------------- stage 3: accumulator and frame FSM ----------------
  acc_state_e r_state, w_state_nxt;
  logic       w_beat, w_start, w_err;

  assign w_beat = r_s3_vld && w_adv;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_beat) w_state_nxt = w_last3 ? ST_IDLE : ST_ACCUM;
  end

  // A FIRST beat inside an open frame throws the partial sum away.
  always_comb begin
    w_start = (r_state == ST_IDLE) || w_first3;
    w_err   = w_beat && (r_state == ST_ACCUM) && w_first3;
  end

  logic [CP_WIDTH-1:0]  r_acc, r_p, w_lim, w_res;
  logic                 r_ovf, r_p_ovf, r_p_vld, r_frame_err;
  logic [CNT_WIDTH-1:0] r_cnt, r_p_beats, w_cnt_nxt;
  logic [XW-1:0]        w_term_pos, w_term, w_base, w_sum;
  logic                 w_ovf_now, w_ovf_tot;

  assign w_term_pos = {{(XW-PW){w_m3[PW-1]}}, w_m3};
  assign w_term     = w_sub3 ? -w_term_pos : w_term_pos;
  assign w_base     = w_start ? {w_c3[CP_WIDTH-1], w_c3} : {r_acc[CP_WIDTH-1], r_acc};
  assign w_sum      = w_base + w_term;
  // Guard bit disagreeing with the CP_WIDTH sign bit means the sum does not fit.
  assign w_ovf_now  = w_sum[XW-1] ^ w_sum[XW-2];
  assign w_lim      = CP_WIDTH'(sat_limit(CP_WIDTH, w_sum[XW-1]));
  assign w_res      = (w_ovf_now && (SATURATE != 1'b0)) ? w_lim : w_sum[CP_WIDTH-1:0];
  assign w_ovf_tot  = w_ovf_now || (!w_start && r_ovf);
  assign w_cnt_nxt  = w_start ? CNT_WIDTH'(1)
                              : ((&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_p         <= '0;
      r_p_ovf     <= 1'b0;
      r_p_beats   <= '0;
      r_p_vld     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_adv) r_p_vld <= w_beat && w_last3;
      if (w_beat) begin
        if (w_last3) begin
          r_p       <= w_res;
          r_p_ovf   <= w_ovf_tot;
          r_p_beats <= w_cnt_nxt;
          r_acc     <= '0;
          r_ovf     <= 1'b0;
          r_cnt     <= '0;
        end else begin
          r_acc     <= w_res;
          r_ovf     <= w_ovf_tot;
          r_cnt     <= w_cnt_nxt;
        end
      end
    end
  end

  assign P_VALID   = r_p_vld;
  assign P         = r_p;
  assign P_OVF     = r_p_ovf;
  assign P_BEATS   = r_p_beats;
  assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a 48-bit instance plus two 40-bit instances
// (saturating and wrapping) share one input stream; results of the 48-bit
// instance are scored against a queue of hand-computed expectations.
module tb_dsp_mac_pipe;
  localparam int W = 18, CPW = 48, CPN = 40, CW = 16;

  logic CLK = 1'b0, RSTN = 1'b0;
  always #5 CLK = ~CLK;

  logic           IN_VALID, P_READY, IN_FIRST, IN_LAST;
  logic [W-1:0]   A, B, D;
  logic [CPW-1:0] C;
  logic [2:0]     OPMODE;

  logic           rdy0, vld0, ovf0, ferr0;
  logic [CPW-1:0] p0;
  logic [CW-1:0]  beats0;
  logic           rdy1, vld1, ovf1, ferr1, rdy2, vld2, ovf2, ferr2;
  logic [CPN-1:0] p1, p2;
  logic [CW-1:0]  beats1, beats2;

  dsp_mac_pipe #(.ABD_WIDTH(W), .CP_WIDTH(CPW), .SATURATE(1'b1), .CNT_WIDTH(CW)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(rdy0), .A(A), .B(B), .D(D),
    .C(C), .OPMODE(OPMODE), .IN_FIRST(IN_FIRST), .IN_LAST(IN_LAST), .P_VALID(vld0),
    .P_READY(P_READY), .P(p0), .P_OVF(ovf0), .P_BEATS(beats0), .FRAME_ERR(ferr0));
  dsp_mac_pipe #(.ABD_WIDTH(W), .CP_WIDTH(CPN), .SATURATE(1'b1), .CNT_WIDTH(CW)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(rdy1), .A(A), .B(B), .D(D),
    .C(C[CPN-1:0]), .OPMODE(OPMODE), .IN_FIRST(IN_FIRST), .IN_LAST(IN_LAST), .P_VALID(vld1),
    .P_READY(P_READY), .P(p1), .P_OVF(ovf1), .P_BEATS(beats1), .FRAME_ERR(ferr1));
  dsp_mac_pipe #(.ABD_WIDTH(W), .CP_WIDTH(CPN), .SATURATE(1'b0), .CNT_WIDTH(CW)) u_wrap (
    .CLK(CLK), .RSTN(RSTN), .IN_VALID(IN_VALID), .IN_READY(rdy2), .A(A), .B(B), .D(D),
    .C(C[CPN-1:0]), .OPMODE(OPMODE), .IN_FIRST(IN_FIRST), .IN_LAST(IN_LAST), .P_VALID(vld2),
    .P_READY(P_READY), .P(p2), .P_OVF(ovf2), .P_BEATS(beats2), .FRAME_ERR(ferr2));

  typedef struct {
    logic [W-1:0]   a, b, d;
    logic [CPW-1:0] c;
    logic [2:0]     op;
    logic           first, last;
    logic [CPW-1:0] ep;
    logic           eovf;
    logic [CW-1:0]  ebeats;
  } vec_t;

  typedef struct {
    logic [CPW-1:0] p;
    logic           ovf;
    logic [CW-1:0]  beats;
  } res_t;

  vec_t tbl[$];
  res_t expq[$];
  int   checks = 0, fails = 0, ferr_cnt = 0;
  bit   done;

  function automatic vec_t mk(input int a, input int b, input int d, input longint c,
                              input logic [2:0] op, input bit f, input bit l,
                              input longint ep, input bit eo, input int eb);
    vec_t v;
    v.a = a[W-1:0]; v.b = b[W-1:0]; v.d = d[W-1:0]; v.c = c[CPW-1:0];
    v.op = op; v.first = f; v.last = l;
    v.ep = ep[CPW-1:0]; v.eovf = eo; v.ebeats = eb[CW-1:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded); queue its result if LAST.
  task automatic send(input vec_t v, input bit track);
    bit ok;
    ok = 1'b0;
    A = v.a; B = v.b; D = v.d; C = v.c; OPMODE = v.op;
    IN_FIRST = v.first; IN_LAST = v.last; IN_VALID = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (rdy0) begin
        @(posedge CLK); #1;
        ok = 1'b1;
        if (track && v.last) expq.push_back('{p: v.ep, ovf: v.eovf, beats: v.ebeats});
      end
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL send_timeout: beat not accepted within 200 cycles");
      IN_VALID = 1'b0;
    end
  endtask

  task automatic wait_vld(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      seen = vld0;
    end
    if (!seen) begin
      checks++; fails++;
      $display("FAIL wait_p_valid: P_VALID not seen within 40 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    int  e0;
    bit  seen;
    vec_t v;

    IN_VALID = 0; P_READY = 1; IN_FIRST = 0; IN_LAST = 0;
    A = '0; B = '0; D = '0; C = '0; OPMODE = '0;
    done = 1'b0;

    // Vector table: {inputs, expected result on LAST beats}
    tbl.push_back(mk(3, 4, 10, 100, 3'b011, 1, 1, 118, 0, 1));
    tbl.push_back(mk(-2, 5, 0, 7, 3'b000, 1, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b000, 0, 1, -33, 0, 4));
    tbl.push_back(mk(-2, 5, 0, 7, 3'b100, 1, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(-2, 5, 0, 999, 3'b100, 0, 1, 47, 0, 4));
    tbl.push_back(mk(-3, 6, -20, -1, 3'b001, 1, 1, 41, 0, 1));
    tbl.push_back(mk(5, 5, 0, 10, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, -1, 0, 777, 3'b000, 0, 1, 34, 0, 2));
    tbl.push_back(mk(7, 3, 1, 0, 3'b111, 1, 1, 14, 0, 1));
    tbl.push_back(mk(-131072, -131072, -131072, 0, 3'b001, 1, 1, 64'sd34359738368, 0, 1));
    tbl.push_back(mk(131071, 0, -131072, -5, 3'b011, 1, 1, -64'sd17179738117, 0, 1));

    fork
      begin : monitor
        res_t e;
        forever begin
          @(negedge CLK);
          if (ferr0) ferr_cnt++;
          if (vld0 && P_READY) begin
            if (expq.size() == 0) begin
              checks++; fails++;
              $display("FAIL unexpected_result: P=0x%0h with nothing expected", p0);
            end else begin
              e = expq.pop_front();
              chk("P", p0, e.p);
              chk("P_OVF", ovf0, e.ovf);
              chk("P_BEATS", beats0, e.beats);
            end
          end
        end
      end
    join_none

    // Reset values on all instances
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_vld0", vld0, 0); chk("rst_p0", p0, 0); chk("rst_ovf0", ovf0, 0);
    chk("rst_beats0", beats0, 0); chk("rst_ferr0", ferr0, 0); chk("rst_rdy0", rdy0, 0);
    chk("rst_vld1", vld1, 0); chk("rst_p1", p1, 0); chk("rst_ovf1", ovf1, 0);
    chk("rst_beats1", beats1, 0); chk("rst_ferr1", ferr1, 0); chk("rst_rdy1", rdy1, 0);
    chk("rst_vld2", vld2, 0); chk("rst_p2", p2, 0); chk("rst_ovf2", ovf2, 0);
    chk("rst_beats2", beats2, 0); chk("rst_ferr2", ferr2, 0); chk("rst_rdy2", rdy2, 0);
    @(posedge CLK); #2 RSTN = 1'b1;
    @(negedge CLK); chk("rdy_before_first_edge", rdy0, 0);
    @(negedge CLK); chk("rdy_after_release", rdy0, 1);

    // Table back-to-back: one beat per cycle
    @(posedge CLK); #1;
    t0 = $time;
    foreach (tbl[i]) send(tbl[i], 1'b1);
    t1 = $time;
    IN_VALID = 1'b0;
    chk("throughput_cycles", 64'((t1 - t0) / 10), 64'(tbl.size()));
    repeat (10) @(posedge CLK); #1;
    chk("drain_table", expq.size(), 0);

    // Latency of a single-beat frame
    send(tbl[0], 1'b1);
    IN_VALID = 1'b0;
    @(negedge CLK); chk("lat_edge_n", vld0, 0);
    @(negedge CLK); chk("lat_edge_n1", vld0, 0);
    @(negedge CLK); chk("lat_edge_n2", vld0, 0);
    @(negedge CLK); chk("lat_edge_n3", vld0, 1);
    repeat (3) @(posedge CLK); #1;

    // Backpressure: hold P for 5 cycles while more beats are offered
    P_READY = 1'b0;
    send(mk(2, 3, 0, 1, 3'b000, 1, 1, 7, 0, 1), 1'b1);
    fork
      begin
        send(mk(1, 1, 0, 10, 3'b000, 1, 1, 11, 0, 1), 1'b1);
        send(mk(2, 2, 0, 20, 3'b000, 1, 1, 24, 0, 1), 1'b1);
        send(mk(3, 3, 0, 30, 3'b000, 1, 1, 39, 0, 1), 1'b1);
        send(mk(4, 4, 0, 40, 3'b000, 1, 1, 56, 0, 1), 1'b1);
        IN_VALID = 1'b0;
      end
      begin
        wait_vld(seen);
        for (int k = 0; k < 5; k++) begin
          chk("stall_in_ready", rdy0, 0);
          chk("stall_p_stable", p0, 7);
          chk("stall_p_valid", vld0, 1);
          @(negedge CLK);
        end
        @(posedge CLK); #1 P_READY = 1'b1;
      end
    join
    repeat (12) @(posedge CLK); #1;
    chk("drain_stall", expq.size(), 0);

    // Random sink stalls over the whole table
    fork
      begin
        foreach (tbl[i]) send(tbl[i], 1'b1);
        IN_VALID = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK); #1;
          P_READY = 1'($urandom_range(0, 1));
        end
        P_READY = 1'b1;
      end
    join
    repeat (12) @(posedge CLK); #1;
    chk("drain_random", expq.size(), 0);

    // FIRST inside an open frame aborts it
    e0 = ferr_cnt;
    send(mk(1, 2, 0, 1000, 3'b000, 1, 0, 0, 0, 0), 1'b1);
    send(mk(1, 3, 0, 0, 3'b000, 0, 0, 0, 0, 0), 1'b1);
    send(mk(2, 4, 0, 50, 3'b000, 1, 0, 0, 0, 0), 1'b1);
    send(mk(1, 1, 0, 0, 3'b000, 0, 1, 59, 0, 2), 1'b1);
    IN_VALID = 1'b0;
    repeat (8) @(posedge CLK); #1;
    chk("frame_err_pulses", ferr_cnt - e0, 1);
    chk("drain_abort", expq.size(), 0);

    // Overflow: 40 beats of (2^17-1)^2; 33rd beat overflows 40 bits
    for (int i = 0; i < 40; i++) begin
      v = mk(131071, 131071, 0, 0, 3'b000, i == 0, i == 39, 64'sd687184281640, 0, 40);
      send(v, 1'b1);
    end
    IN_VALID = 1'b0;
    wait_vld(seen);
    chk("sat_p", p1, 40'h7F_FFFF_FFFF);
    chk("sat_ovf", ovf1, 1);
    chk("sat_beats", beats1, 40);
    chk("wrap_p", p2, 40'd687184281640);
    chk("wrap_ovf", ovf2, 1);
    chk("wrap_beats", beats2, 40);
    repeat (4) @(posedge CLK); #1;

    // Reset mid-frame: partial sum discarded, no FRAME_ERR, outputs clear at once
    e0 = ferr_cnt;
    send(mk(100, 100, 0, 12345, 3'b000, 1, 0, 0, 0, 0), 1'b0);
    send(mk(100, 100, 0, 0, 3'b000, 0, 0, 0, 0, 0), 1'b0);
    IN_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("mid_rst_p", p0, 0);
    chk("mid_rst_beats", beats0, 0);
    chk("mid_rst_vld", vld0, 0);
    chk("mid_rst_rdy", rdy0, 0);
    repeat (2) @(posedge CLK);
    #2 RSTN = 1'b1;
    @(posedge CLK); #1;
    send(mk(3, 3, 0, 9, 3'b000, 0, 0, 0, 0, 0), 1'b1);
    send(mk(1, 2, 0, 0, 3'b000, 0, 1, 20, 0, 2), 1'b1);
    IN_VALID = 1'b0;
    repeat (8) @(posedge CLK); #1;
    chk("rst_no_frame_err", ferr_cnt - e0, 0);
    chk("drain_final", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
